// File: rtl/axis_bcast_pkg.sv
// Shared constants and helpers for the packet-aware AXI4-Stream broadcaster.
package axis_bcast_pkg;

  localparam int MODE_LOSSLESS = 0;
  localparam int MODE_DROP     = 1;

  // Pointer width: one extra bit beyond the index so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : value + 64'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo.sv
// Per-output FIFO with commit pointer. In drop mode a partial packet only becomes
// visible on its tlast write and is rolled back as a whole when the FIFO overflows.
module axis_pkt_fifo
  import axis_bcast_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DROP_MODE  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0]    level;
  logic                dropping;
  logic                do_write;
  logic [DATA_WIDTH:0] mem [DEPTH];

  // Full comes from registered pointers only, so a same-cycle read never makes room.
  assign level         = wr_ptr - rd_ptr;
  assign full          = (level == PTR_DEPTH);
  assign m_axis_tvalid = (commit_ptr != rd_ptr);
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

  // A beat lands in storage only when there is room and the packet is not being discarded.
  always_comb begin
    do_write = wr_en && !full && !((DROP_MODE == MODE_DROP) && dropping);
  end

  // Storage array, written at the write pointer.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

  // Pointer, drop-state and drop-counter update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      dropping   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) rd_ptr <= rd_ptr + PTR_ONE;
      if (DROP_MODE == MODE_DROP) begin
        if (wr_en) begin
          if (dropping) begin
            if (wr_last) dropping <= 1'b0;
          end else if (full) begin
            // Overflow: forget the partial packet; keep discarding until its tlast.
            wr_ptr     <= commit_ptr;
            drop_count <= CNT_WIDTH'(sat_inc(64'(drop_count), CNT_WIDTH));
            dropping   <= !wr_last;
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (wr_last) commit_ptr <= wr_ptr + PTR_ONE;
          end
        end
      end else if (do_write) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        commit_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/axis_broadcaster_pkt.sv
// Fans one AXI4-Stream slave out to NUM_OUT buffered masters with a per-packet enable mask.
// Handshake: a beat moves on any interface exactly in a cycle where tvalid and tready are
// both high at the rising edge; tvalid never depends on tready, and a source holds its
// beat stable until it is taken.
module axis_broadcaster_pkt
  import axis_bcast_pkg::*;
#(
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int DROP_MODE  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic [NUM_OUT-1:0]              out_en,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_OUT-1:0]              m_axis_tvalid,
  output logic [NUM_OUT-1:0]              m_axis_tlast,
  input  logic [NUM_OUT-1:0]              m_axis_tready,
  output logic [NUM_OUT*CNT_WIDTH-1:0]    drop_count
);

  logic               in_packet;
  logic [NUM_OUT-1:0] pkt_mask;
  logic [NUM_OUT-1:0] active;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] wr_en;
  logic               accept;

  // Active outputs for this beat, input ready, and per-output write strobes.
  always_comb begin
    active = in_packet ? pkt_mask : out_en;
    if (reset)                       s_axis_tready = 1'b0;
    else if (DROP_MODE == MODE_DROP) s_axis_tready = 1'b1;
    else                             s_axis_tready = &(~active | ~full);
    accept = s_axis_tvalid && s_axis_tready;
    wr_en  = {NUM_OUT{accept}} & active;
  end

  // Packet tracking: the mask is latched on the first beat and held until tlast.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_packet <= 1'b0;
      pkt_mask  <= '0;
    end else if (accept) begin
      if (!in_packet) pkt_mask <= out_en;
      in_packet <= !s_axis_tlast;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    axis_pkt_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DROP_MODE  (DROP_MODE),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en[i]),
      .wr_last       (s_axis_tlast),
      .wr_data       (s_axis_tdata),
      .full          (full[i]),
      .m_axis_tdata  (m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .m_axis_tvalid (m_axis_tvalid[i]),
      .m_axis_tlast  (m_axis_tlast[i]),
      .m_axis_tready (m_axis_tready[i]),
      .drop_count    (drop_count[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule
